seg_scan_driver: RTL
====================

# seg_scan_driver

Parametrised time-multiplexed driver for a common-anode multi-digit 7-segment display. Scans DIGITS digit slots from a double-buffered digit register and adds per-digit blanking, decimal points, PWM brightness and a tear-free load handshake. It sits between the datapath and the board display pins, replacing the fixed two-mode, 8-slot scanner in the top level.

## Interface
Parameters:
- DIGITS, 8, number of digit slots; legal range 2..8.
- DIV_W, 17, slot prescaler width; each slot lasts 2^DIV_W clocks.
- BRIGHT_W, 4, brightness code width; must be ≤ DIV_W.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  new frame data offered.
- load_ready  out  1  driver can accept a frame.
- load_digits  in  4*DIGITS  hex nibbles; nibble i, at [4i+3:4i], drives slot i.
- load_dp  in  DIGITS  decimal point per slot, 1 = lit.
- load_blank  in  DIGITS  1 = slot forced dark.
- bright  in  BRIGHT_W  brightness code; sampled live, not buffered.
- anode  out  DIGITS  active-low digit select.
- cathode  out  8  active-low segments, order {dp,g,f,e,d,c,b,a}.
- frame_start  out  1  one-cycle pulse when slot 0 begins.

## Operation
- Registers:
  - div_cnt (DIV_W bits) increments every clock.
  - slot (clog2 DIGITS bits) advances when div_cnt wraps. It goes from DIGITS-1 back to 0, so non-power-of-two DIGITS is supported.
- Double buffer: a pending register (digits/dp/blank) and an active register. The display always uses the active register.
- Handshake:
  - A transfer occurs when load_valid && load_ready in the same cycle; the pending register captures the load buses.
  - load_ready drops the next cycle and stays low until pending is copied to active.
  - The copy happens on the cycle slot wraps DIGITS-1→0. load_ready returns high that same cycle.
  - The active register therefore never changes mid-frame.
- Slot output:
  - A slot is dark (anode bit 1, cathode 8'hFF) when its blank bit is set, or it is LZB-blanked, or PWM is off.
  - Otherwise its anode bit is 0 and cathode = {~dp, seg(nibble)}.
  - All other anode bits are 1.
- Glyphs: 0-9 and A-F (b, C, d, E, F shapes as in the package table).
- PWM: on when div_cnt[DIV_W-1 -: BRIGHT_W] ≤ bright. Max code = 100% duty; code 0 = 1/2^BRIGHT_W duty.

## Timing
- Reset values:
  - anode all 1s, cathode 8'hFF, frame_start 0, load_ready 1.
  - div_cnt 0, slot 0, pending and active registers 0 with blank all 1s, so the display is dark until the first frame.
- anode/cathode are registered: 1-cycle latency from the slot/div_cnt state to the pins.
- frame_start is high in the first output cycle of slot 0.
- The first frame loaded after reset is displayed from the next slot-0 boundary.
- A load accepted in the copy cycle itself is not lost: it is captured into pending and shown one frame later. The copy uses the old pending value.
- Reset mid-frame: outputs go dark immediately (asynchronously); any pending frame is discarded.
- bright changes take effect within one cycle (glitch-free at slot granularity is not required).

## Configuration
- SEG_LZB_EN defined: leading-zero blanking.
  - Slot i (i ≥ 1) is dark if its nibble and all nibbles of slots above it are 0.
  - Slot 0 is never LZB-blanked.
  - The LZB mask is evaluated from the active register.
  - A dp bit on an LZB-blanked slot is suppressed.
- SEG_LZB_EN undefined: zero nibbles display as "0"; only load_blank darkens slots.

## Structure
- Package seg_scan_pkg holds:
  - the 16-entry glyph constant table (active-low, g..a);
  - SEG_OFF = 8'hFF;
  - the cathode bit-index constants.
- Sub-module seg_hex_decode: a 4-bit to 7-bit combinational decoder using the package table, instantiated once on the muxed nibble (not per digit).

## Test plan
All scenarios use DIGITS=4, DIV_W=4, BRIGHT_W=2.
- Reset, then no load → anode=4'hF, cathode=8'hFF for 3 full frames; load_ready=1.
- Load digits 16'h1234, dp=4'b0010, blank=0, bright=3 → from next frame, slot0 anode=4'b1110 with cathode=~{0,seg(4)}; slot1 cathode bit7=0; each slot held 16 clocks; frame_start every 64 clocks.
- Two loads (16'h1111, then 16'h2222) sent mid-frame → second is stalled (load_ready=0); only 16'h1111 appears, at the boundary; no slot shows a mixed frame.
- bright=0 → each slot lit 4 of 16 clocks; bright=2 → lit 12 of 16 clocks.
- SEG_LZB_EN, digits 16'h0050 → slots 3 and 2 dark, slot1 shows 5, slot0 shows 0. Digits 16'h0000 → only slot0 lit with "0". Without the macro, all four slots lit.
- Reset asserted mid-slot2 → anode=4'hF in the same cycle. After release, nothing is displayed and load_ready=1.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table, segment bit indices, off pattern.
package seg_scan_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; glyphs 0-9, A, b, C, d, E, F.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] glyph(input logic [3:0] nibble);
        return GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = glyph(nibble);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered, tear-free frame load.
// Optional feature: define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned DIV_W    = 17,
    parameter int unsigned BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_digits,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic [DIGITS-1:0]     load_blank,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            cathode,
    output logic                  frame_start
);

    localparam int unsigned        SLOT_W    = $clog2(DIGITS);
    localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(DIGITS - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [SLOT_W-1:0]   slot;
    logic                full;
    logic [4*DIGITS-1:0] pend_digits, act_digits;
    logic [DIGITS-1:0]   pend_dp, act_dp, pend_blank, act_blank;

    logic                slot_end, frame_end, take;
    logic [3:0]          nibble;
    logic                dp_bit, blank_bit, lzb_bit, pwm_on, lit;
    logic [DIGITS-1:0]   lzb_mask;
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   anode_d;
    logic [7:0]          cathode_d;

    assign slot_end  = &div_cnt;
    assign frame_end = slot_end && (slot == LAST_SLOT);
    // Ready stays high in the copy cycle: the copy reads the old pending value,
    // so a frame accepted in that same cycle lands safely in pending.
    assign load_ready = !full || frame_end;
    assign take       = load_valid && load_ready;

`ifdef SEG_LZB_EN
    logic zero_run;

    always_comb begin
        lzb_mask = '0;
        zero_run = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (act_digits[4*i +: 4] == 4'h0);
            lzb_mask[i] = zero_run;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    always_comb begin
        nibble    = '0;
        dp_bit    = 1'b0;
        blank_bit = 1'b1;
        lzb_bit   = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (slot == SLOT_W'(i)) begin
                nibble    = act_digits[4*i +: 4];
                dp_bit    = act_dp[i];
                blank_bit = act_blank[i];
                lzb_bit   = lzb_mask[i];
            end
        end
    end

    seg_hex_decode u_decode (
        .nibble (nibble),
        .seg    (seg_n)
    );

    assign pwm_on = (div_cnt[DIV_W-1 -: BRIGHT_W] <= bright);
    assign lit    = !blank_bit && !lzb_bit && pwm_on;

    always_comb begin
        anode_d   = '1;
        cathode_d = SEG_OFF;
        if (lit) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (slot == SLOT_W'(i)) begin
                    anode_d[i] = 1'b0;
                end
            end
            cathode_d[SEG_DP]      = ~dp_bit;
            cathode_d[SEG_G:SEG_A] = seg_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            slot        <= '0;
            full        <= 1'b0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blank  <= '1;
            act_digits  <= '0;
            act_dp      <= '0;
            act_blank   <= '1;
            anode       <= '1;
            cathode     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (slot_end) begin
                slot <= frame_end ? '0 : slot + 1'b1;
            end

            if (frame_end && full) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
            end

            if (take) begin
                pend_digits <= load_digits;
                pend_dp     <= load_dp;
                pend_blank  <= load_blank;
                full        <= 1'b1;
            end else if (frame_end) begin
                full <= 1'b0;
            end

            anode       <= anode_d;
            cathode     <= cathode_d;
            frame_start <= (slot == '0) && (div_cnt == '0);
        end
    end

endmodule
